// File: rtl/serial_sub16_pkg.sv
// Shared constants, FSM state and flag payload for the nibble-serial subtractor.
package serial_sub16_pkg;

    localparam int unsigned SUB_WIDTH = 16;
    localparam int unsigned SUB_SLICE = 4;

    // Counter width for n slices; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SUB_CNT_W = cnt_width(SUB_WIDTH / SUB_SLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    typedef struct packed {
        logic bo;
        logic zero;
        logic ovf;
    } sub_flags_t;

endpackage

// File: rtl/serial_sub16_if.sv
// Operand/result handshake bundle for serial_sub16.
interface serial_sub16_if
    import serial_sub16_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bo;
    logic             zero;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, bi, out_ready,
        output in_ready, out_valid, diff, bo, zero, ovf
    );

    modport master (
        output in_valid, a, b, bi, out_ready,
        input  in_ready, out_valid, diff, bo, zero, ovf
    );
endinterface

// File: rtl/serial_sub16_sub4bit.sv
// Combinational W-bit subtract slice with borrow in/out.
module sub4bit #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);
    // One extra bit captures the borrow: a negative result wraps with bit W set.
    logic [W:0] full;

    always_comb begin
        full = (W+1)'(a) - (W+1)'(b) - (W+1)'(bi);
        d    = full[W-1:0];
        bo   = full[W];
    end
endmodule

// File: rtl/serial_sub16.sv
// Nibble-serial a - b - bi: one slice per clock through a single registered borrow,
// valid/ready on both sides, with borrow/zero/overflow flags latched on completion.
module serial_sub16
    import serial_sub16_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH,
    parameter int unsigned SLICE = SUB_SLICE  // WIDTH must be a multiple of SLICE
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_sub16_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    sub_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NSLICE-1:0][SLICE-1:0] a_q, a_d;
    logic [NSLICE-1:0][SLICE-1:0] b_q, b_d;
    logic [NSLICE-1:0][SLICE-1:0] diff_q, diff_d;
    logic borrow_q, borrow_d;
    sub_flags_t flags_q, flags_d;
    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;

    logic [SLICE-1:0] slice_d;
    logic             slice_bo;

    sub4bit #(
        .W (SLICE)
    ) u_slice (
        .a  (a_q[cnt_q]),
        .b  (b_q[cnt_q]),
        .bi (borrow_q),
        .d  (slice_d),
        .bo (slice_bo)
    );

    // Next-state, datapath updates and registered handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        borrow_d    = borrow_q;
        diff_d      = diff_q;
        flags_d     = flags_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bi;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[cnt_q] = slice_d;
                borrow_d      = slice_bo;
                if (cnt_q == LAST) begin
                    flags_d.bo   = slice_bo;
                    flags_d.zero = ~|diff_d;
                    flags_d.ovf  = (a_q[NSLICE-1][SLICE-1] != b_q[NSLICE-1][SLICE-1]) &&
                                   (diff_d[NSLICE-1][SLICE-1] != a_q[NSLICE-1][SLICE-1]);
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            borrow_q    <= borrow_d;
            diff_q      <= diff_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bo        = flags_q.bo;
    assign bus.zero      = flags_q.zero;
    assign bus.ovf       = flags_q.ovf;

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16: directed corner cases, back-pressure,
// mid-operation reset and randomized traffic against a whole-word arithmetic model.
module tb_serial_sub16;
    import serial_sub16_pkg::*;

    localparam int unsigned NSL = SUB_WIDTH / SUB_SLICE;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_sub16_if bus ();

    serial_sub16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] last_diff;
    logic        last_bo, last_zero, last_ovf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction, checked against plain word arithmetic.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input int pre_gap, input int ready_gap,
                          input bit junk, input bit hold_chk);
        logic [16:0] full;
        logic [15:0] ed;
        logic        ebo, ez, eov;
        int          n;
        full = {1'b0, a} - {1'b0, b} - 17'(bi);
        ed   = full[15:0];
        ebo  = full[16];
        ez   = (ed == 16'h0000);
        eov  = (a[15] != b[15]) && (ed[15] != a[15]);

        repeat (pre_gap) tick();
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a  = a;
        bus.b  = b;
        bus.bi = bi;
        tick();
        bus.in_valid = junk;
        bus.a  = 16'($urandom);
        bus.b  = 16'($urandom);
        bus.bi = 1'($urandom);
        check("in_ready_run", 32'(bus.in_ready), 32'd0);

        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(NSL));
        bus.in_valid = 1'b0;

        for (int r = 0; r < ready_gap; r++) begin
            if (hold_chk) begin
                bus.in_valid = 1'((r % 2) == 0);
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
            end
            tick();
            if (hold_chk) begin
                check("hold_diff", 32'(bus.diff), 32'(ed));
                check("hold_bo", 32'(bus.bo), 32'(ebo));
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            end
        end
        bus.in_valid = 1'b0;

        check("diff", 32'(bus.diff), 32'(ed));
        check("bo", 32'(bus.bo), 32'(ebo));
        check("zero", 32'(bus.zero), 32'(ez));
        check("ovf", 32'(bus.ovf), 32'(eov));
        last_diff = bus.diff;
        last_bo   = bus.bo;
        last_zero = bus.zero;
        last_ovf  = bus.ovf;

        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("in_ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        logic [15:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a  = '0;
        bus.b  = '0;
        bus.bi = 1'b0;
        rst_n  = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_flags", 32'({bus.bo, bus.zero, bus.ovf}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("rel_out_valid", 32'(bus.out_valid), 32'd0);

        run_op(16'h1234, 16'h0234, 1'b0, 0, 0, 1'b0, 1'b0);
        check("d1_diff", 32'(last_diff), 32'h1000);
        check("d1_flags", 32'({last_bo, last_zero, last_ovf}), 32'b000);

        run_op(16'h0000, 16'h0001, 1'b0, 0, 0, 1'b1, 1'b0);
        check("d2_diff", 32'(last_diff), 32'hFFFF);
        check("d2_bo_ovf", 32'({last_bo, last_ovf}), 32'b10);

        run_op(16'h8000, 16'h0001, 1'b0, 1, 0, 1'b0, 1'b0);
        check("d3_diff", 32'(last_diff), 32'h7FFF);
        check("d3_bo_ovf", 32'({last_bo, last_ovf}), 32'b01);

        run_op(16'h0005, 16'h0004, 1'b1, 0, 1, 1'b0, 1'b0);
        check("d4_diff", 32'(last_diff), 32'h0000);
        check("d4_zero_bo", 32'({last_zero, last_bo}), 32'b10);

        run_op(16'h0000, 16'h0000, 1'b1, 0, 0, 1'b0, 1'b0);
        check("d5_diff", 32'(last_diff), 32'hFFFF);
        check("d5_bo", 32'(last_bo), 32'd1);

        // Back-pressure window with ignored operand pulses, then a fresh op.
        run_op(16'hABCD, 16'h1234, 1'b1, 0, 10, 1'b1, 1'b1);
        check("bp_diff", 32'(last_diff), 32'h9998);
        run_op(16'h4321, 16'h8765, 1'b0, 0, 0, 1'b0, 1'b0);
        check("bp_next_diff", 32'(last_diff), 32'hBBBC);

        // Reset after two slices have been processed.
        bus.in_valid = 1'b1;
        bus.a  = 16'hFFFF;
        bus.b  = 16'h0001;
        bus.bi = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_diff", 32'(bus.diff), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen++;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);

        for (int t = 0; t < 1000; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'h8000;
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
